// File: rtl/sflash_pkg.sv
//------------------------------------------------------------------------------
// Module   : sflash_pkg
// Purpose  : Shared format codes, FSM encoding and lane helpers for sflash_xfer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sflash_pkg;

    localparam logic [2:0] FMT_NONE    = 3'b000;
    localparam logic [2:0] FMT_SINGLE  = 3'b010;
    localparam logic [2:0] FMT_DUAL_TX = 3'b100;
    localparam logic [2:0] FMT_DUAL_RX = 3'b101;
    localparam logic [2:0] FMT_QUAD_TX = 3'b110;
    localparam logic [2:0] FMT_QUAD_RX = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_LAST = 3'b100
    } state_t;

    // No-select formats shift like single so the word still completes.
    function automatic logic [2:0] lanes(input logic [2:0] fmt);
        case (fmt[2:1])
            2'b10:   lanes = 3'd2;
            2'b11:   lanes = 3'd4;
            default: lanes = 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] oe_mask(input logic [2:0] fmt);
        case (fmt)
            FMT_SINGLE, 3'b011: oe_mask = 4'b0001;
            FMT_DUAL_TX:        oe_mask = 4'b0011;
            FMT_QUAD_TX:        oe_mask = 4'b1111;
            default:            oe_mask = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sflash_div.sv
//------------------------------------------------------------------------------
// Module   : sflash_div
// Purpose  : Half-period divider; pulses tick every prescale+1 clocks when enabled.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sflash_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] prescale,
    output logic       tick
);

    logic [3:0] cnt;

    // Count is held at zero while disabled so the first tick lands on the
    // first enabled cycle.
    assign tick = en && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (!en) begin
            cnt <= 4'd0;
        end else if (tick) begin
            cnt <= prescale;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sflash_xfer.sv
//------------------------------------------------------------------------------
// Module   : sflash_xfer
// Purpose  : SPI/dual/quad flash word shifter with dummy cycles and multi-CS.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sflash_xfer
    import sflash_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCS   = 1,
    parameter  int BW    = ((WIDTH / 8) > 1) ? $clog2(WIDTH / 8) : 1,
    localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic [BW-1:0]    nbytes,
    input  logic [4:0]       dummy,
    input  logic [2:0]       format,
    input  logic [CSW-1:0]   cs_sel,
    input  logic [3:0]       prescale,
    output logic [WIDTH-1:0] dout,
    output logic             sclk,
    output logic [NCS-1:0]   cs_n,
    input  logic [3:0]       qdi,
    output logic [3:0]       qdo,
    output logic [3:0]       oe
);

    localparam int NB = WIDTH / 8;

    state_t           state;
    state_t           state_nx;
    logic             tick;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [3:0]       next_bits;
    logic [5:0]       cyc;
    logic [5:0]       total;
    logic [5:0]       bits;
    logic [4:0]       dum;
    logic [2:0]       fmt;
    logic [5:0]       n_acc;
    logic [5:0]       bits_acc;
    logic [5:0]       total_acc;
    logic [NCS-1:0]   cs_live;
    logic             data_phase;

    sflash_div u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (state != ST_IDLE),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        n_acc = 6'(nbytes) + 6'd1;
        if (n_acc > 6'(NB)) begin
            n_acc = 6'(NB);
        end
        bits_acc = n_acc << 3;
        case (lanes(format))
            3'd4:    total_acc = {1'b0, dummy} + (bits_acc >> 2);
            3'd2:    total_acc = {1'b0, dummy} + (bits_acc >> 1);
            default: total_acc = {1'b0, dummy} + bits_acc;
        endcase
    end

    always_comb begin
        cs_live = '1;
        for (int i = 0; i < NCS; i++) begin
            if ((format[2:1] != 2'b00) && (cs_sel == CSW'(i))) begin
                cs_live[i] = 1'b0;
            end
        end
    end

    // sr is left-aligned at accept, so outgoing bits always sit at the top and
    // received bits accumulate right-aligned at the bottom.
    always_comb begin
        case (lanes(fmt))
            3'd4: begin
                next_bits  = sr[WIDTH-1 -: 4];
                sr_shifted = {sr[WIDTH-5:0], qdi};
            end
            3'd2: begin
                next_bits  = {2'b00, sr[WIDTH-1 -: 2]};
                sr_shifted = {sr[WIDTH-3:0], qdi[1:0]};
            end
            default: begin
                next_bits  = {3'b000, sr[WIDTH-1]};
                sr_shifted = {sr[WIDTH-2:0], qdi[1]};
            end
        endcase
    end

    assign data_phase = (cyc >= {1'b0, dum});
    assign ready      = (state == ST_IDLE);
    assign oe         = ((state == ST_RUN) && data_phase) ? oe_mask(fmt) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // RUN ends on the last rising edge; LAST then holds sclk high for one
    // more half-period before the word is published.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (wr) state_nx = ST_RUN;
            ST_RUN:  if (tick && !sclk && (cyc == total - 6'd1)) state_nx = ST_LAST;
            ST_LAST: if (tick) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk  <= 1'b1;
            cs_n  <= '1;
            qdo   <= 4'b0000;
            dout  <= '0;
            sr    <= '0;
            cyc   <= 6'd0;
            total <= 6'd0;
            bits  <= 6'd0;
            dum   <= 5'd0;
            fmt   <= FMT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cs_n <= cs_live;
                    sclk <= 1'b1;
                    if (wr) begin
                        sr    <= din << (6'(WIDTH) - bits_acc);
                        bits  <= bits_acc;
                        total <= total_acc;
                        dum   <= dummy;
                        fmt   <= format;
                        cyc   <= 6'd0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (data_phase) qdo <= next_bits;
                        end else begin
                            sclk <= 1'b1;
                            if (data_phase) sr <= sr_shifted;
                            cyc <= cyc + 6'd1;
                        end
                    end
                end
                ST_LAST: begin
                    if (tick) begin
                        dout <= sr & ({WIDTH{1'b1}} >> (6'(WIDTH) - bits));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sflash_xfer.sv
//------------------------------------------------------------------------------
// Module   : tb_sflash_xfer
// Purpose  : Directed self-checking bench for sflash_xfer (WIDTH=32, NCS=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sflash_xfer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] din = 32'h0;
    logic [1:0]  nbytes = 2'd0;
    logic [4:0]  dummy = 5'd0;
    logic [2:0]  format = 3'b000;
    logic [0:0]  cs_sel = 1'b0;
    logic [3:0]  prescale = 4'd0;
    logic        ready;
    logic [31:0] dout;
    logic        sclk;
    logic [1:0]  cs_n;
    logic [3:0]  qdi;
    logic [3:0]  qdo;
    logic [3:0]  oe;

    logic        loop_en = 1'b0;
    logic        model_en = 1'b0;
    logic [3:0]  qdi_m = 4'h0;
    logic [31:0] mword = 32'h0;
    int          mdummy = 0;

    int checks = 0;
    int failures = 0;

    int fall_cnt = 0, fall_base = 0, rise_cnt = 0, rise_base = 0;
    int fidx, ridx;
    logic [1:0] cap [0:255];
    realtime    ftime [0:255];
    realtime    rtime [0:255];

    assign qdi = loop_en ? {2'b00, qdo[0], 1'b0} : (model_en ? qdi_m : 4'h0);

    sflash_xfer #(.WIDTH(32), .NCS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .wr       (wr),
        .din      (din),
        .nbytes   (nbytes),
        .dummy    (dummy),
        .format   (format),
        .cs_sel   (cs_sel),
        .prescale (prescale),
        .dout     (dout),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .qdi      (qdi),
        .qdo      (qdo),
        .oe       (oe)
    );

    always #5 clk = ~clk;

    // Flash model presents nibbles after the dummy cycles and records qdo.
    always @(negedge sclk) begin
        fidx = fall_cnt - fall_base;
        fall_cnt++;
        if (fidx >= 0 && fidx < 256) ftime[fidx] = $realtime;
        if (model_en && fidx >= mdummy && (fidx - mdummy) < 8)
            qdi_m = mword[31 - 4 * (fidx - mdummy) -: 4];
        #1;
        if (fidx >= 0 && fidx < 256) cap[fidx] = qdo[1:0];
    end

    always @(posedge sclk) begin
        ridx = rise_cnt - rise_base;
        rise_cnt++;
        if (ridx >= 0 && ridx < 256) rtime[ridx] = $realtime;
    end

    task automatic run_wr(input logic [31:0] d, input logic [1:0] nb, input logic [4:0] dm,
                          input logic [2:0] f, input logic [0:0] cs, input logic [3:0] ps,
                          input int inject_at, output int lat, output logic [3:0] oe_first,
                          output logic [3:0] oe_or, output logic [1:0] cs_mid);
        @(negedge clk);
        din = d; nbytes = nb; dummy = dm; format = f; cs_sel = cs; prescale = ps; wr = 1'b1;
        fall_base = fall_cnt;
        rise_base = rise_cnt;
        @(posedge clk);
        #1;
        wr = 1'b0;
        oe_first = oe;
        oe_or = oe;
        cs_mid = cs_n;
        lat = 0;
        while (lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            oe_or |= oe;
            if (lat == inject_at + 2) cs_mid = cs_n;
            if (lat == inject_at) begin
                din = 32'hFFFF_FFFF; nbytes = 2'd3; cs_sel = ~cs_sel; wr = 1'b1;
            end else begin
                wr = 1'b0;
            end
            if (ready === 1'b1) break;
        end
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
        checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
        checks++; if (qdo !== 4'h0) begin failures++; $display("FAIL reset_qdo got=%h exp=0", qdo); end
        checks++; if (oe !== 4'h0) begin failures++; $display("FAIL reset_oe got=%b exp=0000", oe); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_loopback();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        loop_en = 1'b1;
        run_wr(32'h0000_00A5, 2'd0, 5'd0, 3'b010, 1'b0, 4'd0, -10, lat, oe_f, oe_o, csm);
        checks++; if (lat !== 17) begin failures++; $display("FAIL single_latency got=%0d exp=17", lat); end
        checks++; if (dout !== 32'h0000_00A5) begin failures++; $display("FAIL single_dout got=%h exp=000000a5", dout); end
        checks++; if (oe_f !== 4'b0001) begin failures++; $display("FAIL single_oe_data got=%b exp=0001", oe_f); end
        checks++; if (oe !== 4'b0000) begin failures++; $display("FAIL single_oe_idle got=%b exp=0000", oe); end
        checks++; if (rise_cnt - rise_base !== 8) begin failures++; $display("FAIL single_rises got=%0d exp=8", rise_cnt - rise_base); end
        checks++; if (csm !== 2'b10) begin failures++; $display("FAIL single_cs_n got=%b exp=10", csm); end
        loop_en = 1'b0;
    endtask

    task automatic test_quad_rx();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        mword = 32'hDEAD_BEEF; mdummy = 6; model_en = 1'b1;
        run_wr(32'h0, 2'd3, 5'd6, 3'b111, 1'b0, 4'd1, -10, lat, oe_f, oe_o, csm);
        checks++; if (lat !== 57) begin failures++; $display("FAIL quad_latency got=%0d exp=57", lat); end
        checks++; if (dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL quad_dout got=%h exp=deadbeef", dout); end
        checks++; if (oe_o !== 4'b0000) begin failures++; $display("FAIL quad_oe got=%b exp=0000", oe_o); end
        checks++; if (rise_cnt - rise_base !== 14) begin failures++; $display("FAIL quad_rises got=%0d exp=14", rise_cnt - rise_base); end
        model_en = 1'b0;
    endtask

    task automatic test_dual_tx();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        logic [1:0] exp_seq [0:7];
        exp_seq = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        run_wr(32'h0000_1234, 2'd1, 5'd0, 3'b100, 1'b0, 4'd3, -10, lat, oe_f, oe_o, csm);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== exp_seq[i]) begin
                failures++; $display("FAIL dual_qdo[%0d] got=%0d exp=%0d", i, cap[i], exp_seq[i]);
            end
        end
        checks++; if (lat !== 65) begin failures++; $display("FAIL dual_latency got=%0d exp=65", lat); end
        checks++; if (rtime[0] - ftime[0] != 40.0) begin failures++; $display("FAIL dual_half got=%0t exp=40", rtime[0] - ftime[0]); end
        checks++; if (oe_f !== 4'b0011) begin failures++; $display("FAIL dual_oe got=%b exp=0011", oe_f); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL dual_dout got=%h exp=0", dout); end
    endtask

    task automatic test_cs_select();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        @(negedge clk); cs_sel = 1'b1; format = 3'b010;
        @(posedge clk); #1;
        checks++; if (cs_n !== 2'b01) begin failures++; $display("FAIL cs_sel1 got=%b exp=01", cs_n); end
        @(negedge clk); format = 3'b000;
        @(posedge clk); #1;
        checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL cs_nosel got=%b exp=11", cs_n); end
        loop_en = 1'b1;
        // cs_sel flips to 0 at cycle 4 of the transfer.
        run_wr(32'h0000_003C, 2'd0, 5'd0, 3'b010, 1'b1, 4'd0, 4, lat, oe_f, oe_o, csm);
        checks++; if (csm !== 2'b01) begin failures++; $display("FAIL cs_hold_run got=%b exp=01", csm); end
        checks++; if (dout !== 32'h0000_003C) begin failures++; $display("FAIL cs_dout got=%h exp=0000003c", dout); end
        @(posedge clk); #1;
        checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL cs_after_idle got=%b exp=10", cs_n); end
        loop_en = 1'b0;
    endtask

    task automatic test_wr_ignored();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        loop_en = 1'b1;
        run_wr(32'h0000_005A, 2'd0, 5'd0, 3'b010, 1'b0, 4'd0, 4, lat, oe_f, oe_o, csm);
        checks++; if (lat !== 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", lat); end
        checks++; if (dout !== 32'h0000_005A) begin failures++; $display("FAIL ignore_dout got=%h exp=0000005a", dout); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ignore_no_restart got=%b exp=1", ready); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        loop_en = 1'b1;
        @(negedge clk);
        din = 32'h0000_00C3; nbytes = 2'd0; dummy = 5'd0; format = 3'b010; cs_sel = 1'b0;
        prescale = 4'd2; wr = 1'b1;
        @(posedge clk); #1; wr = 1'b0;
        k = 0;
        while (sclk !== 1'b0 && k < 100) begin @(posedge clk); #1; k++; end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL mid_sclk_low got=%b exp=0", sclk); end
        checks++; if (oe !== 4'b0001) begin failures++; $display("FAIL mid_oe_active got=%b exp=0001", oe); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL rstmid_sclk got=%b exp=1", sclk); end
        checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=11", cs_n); end
        checks++; if (oe !== 4'b0000) begin failures++; $display("FAIL rstmid_oe got=%b exp=0000", oe); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rstmid_dout got=%h exp=0", dout); end
        @(negedge clk); rst = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] oe_f, oe_o; logic [1:0] csm;
        loop_en = 1'b1;
        run_wr(32'h0000_8142, 2'd1, 5'd2, 3'b010, 1'b0, 4'd0, -10, lat, oe_f, oe_o, csm);
        checks++; if (lat !== 37) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=37", lat); end
        checks++; if (dout !== 32'h0000_8142) begin failures++; $display("FAIL b2b_first_dout got=%h exp=00008142", dout); end
        checks++; if (oe_f !== 4'b0000) begin failures++; $display("FAIL b2b_dummy_oe got=%b exp=0000", oe_f); end
        run_wr(32'hC0FF_EE11, 2'd3, 5'd0, 3'b010, 1'b0, 4'd0, -10, lat, oe_f, oe_o, csm);
        checks++; if (lat !== 65) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=65", lat); end
        checks++; if (dout !== 32'hC0FF_EE11) begin failures++; $display("FAIL b2b_second_dout got=%h exp=c0ffee11", dout); end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_loopback();
        test_quad_rx();
        test_dual_tx();
        test_cs_select();
        test_wr_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

`default_nettype wire
